gshare_pht_ctrl: RTL and testbench

GSHARE_PHT_CTRL -- requirements
Module: gshare_pht_ctrl

---
 rtl/gshare_pht_ctrl.sv | 168 ++++++++++++++++
 tb/tb_gshare_pht_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht_ctrl.sv
// Gshare pattern-history-table controller: sweeps the single-port PHT SRAM to INIT_VALUE after
// reset, then arbitrates predict reads against read-modify-write counter updates.
// Optional macro PHT_UPDATE_BUF_EN: 2-entry in-order update FIFO instead of one register.
module gshare_pht_ctrl #(
  parameter int unsigned INDEX_W      = 8,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [1:0]  INIT_VALUE   = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               predict_valid,
  output logic               predict_ready,
  input  logic [INDEX_W-1:0] predict_index,
  output logic               predict_resp_valid,
  output logic [1:0]         predict_resp_ctr,
  input  logic               update_valid,
  output logic               update_ready,
  input  logic [INDEX_W-1:0] update_index,
  input  logic               update_taken,
  output logic               init_done,
  output logic               pht_csb,
  output logic               pht_web,
  output logic [INDEX_W-1:0] pht_addr,
  output logic [1:0]         pht_din,
  input  logic [1:0]         pht_dout
);

`ifdef PHT_UPDATE_BUF_EN
  localparam int unsigned UpdDepth = 2;
`else
  localparam int unsigned UpdDepth = 1;
`endif
  localparam int unsigned CntW    = $clog2(UpdDepth + 1);
  localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StInit, StAccept, StUpdWr} state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   sweep_q, sweep_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [INDEX_W-1:0]   upd_idx_q [UpdDepth];
  logic [INDEX_W-1:0]   upd_idx_d [UpdDepth];
  logic                 upd_tkn_q [UpdDepth];
  logic                 upd_tkn_d [UpdDepth];
  logic [CntW-1:0]      upd_cnt_q, upd_cnt_d;
  logic [CntW-1:0]      wr_pos;

  logic upd_pending, starved, pred_grant, upd_push, upd_pop;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  assign upd_pending = (upd_cnt_q != '0);
  assign starved     = upd_pending && (starve_q == StarveW'(STARVE_LIMIT));
  assign init_done   = (state_q != StInit);
  // Readiness is based on the registered count, so a push is refused while full even on a pop.
  assign update_ready = rst_n && (state_q != StInit) && (upd_cnt_q != CntW'(UpdDepth));
  assign upd_push     = update_valid && update_ready;

  assign predict_resp_valid = resp_valid_q;
  assign predict_resp_ctr   = resp_valid_q ? pht_dout : 2'b00;

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    starve_d      = starve_q;
    pht_csb       = 1'b1;
    pht_web       = 1'b1;
    pht_addr      = '0;
    pht_din       = 2'b00;
    predict_ready = 1'b0;
    pred_grant    = 1'b0;
    upd_pop       = 1'b0;

    unique case (state_q)
      StInit: begin
        pht_csb  = 1'b0;
        pht_web  = 1'b0;
        pht_addr = sweep_q;
        pht_din  = INIT_VALUE;
        sweep_d  = sweep_q + 1'b1;
        if (&sweep_q) state_d = StAccept;
      end
      StAccept: begin
        predict_ready = !starved;
        pred_grant    = predict_valid && !starved;
        if (pred_grant) begin
          pht_csb  = 1'b0;
          pht_addr = predict_index;
          if (upd_pending) starve_d = starve_q + 1'b1;
        end else if (upd_pending) begin
          pht_csb  = 1'b0;
          pht_addr = upd_idx_q[0];
          starve_d = '0;
          state_d  = StUpdWr;
        end
      end
      StUpdWr: begin
        pht_csb  = 1'b0;
        pht_web  = 1'b0;
        pht_addr = upd_idx_q[0];
        pht_din  = sat_update(pht_dout, upd_tkn_q[0]);
        upd_pop  = 1'b1;
        state_d  = StAccept;
      end
      default: state_d = StInit;
    endcase

    // Keep the SRAM port quiet while reset is held.
    if (!rst_n) begin
      pht_csb       = 1'b1;
      pht_web       = 1'b1;
      pht_addr      = '0;
      pht_din       = 2'b00;
      predict_ready = 1'b0;
      pred_grant    = 1'b0;
    end
  end

  assign resp_valid_d = pred_grant;

  always_comb begin
    upd_idx_d = upd_idx_q;
    upd_tkn_d = upd_tkn_q;
    if (upd_pop) begin
      for (int i = 0; i < int'(UpdDepth) - 1; i++) begin
        upd_idx_d[i] = upd_idx_q[i+1];
        upd_tkn_d[i] = upd_tkn_q[i+1];
      end
    end
    wr_pos = upd_pop ? upd_cnt_q - 1'b1 : upd_cnt_q;
    for (int i = 0; i < int'(UpdDepth); i++) begin
      if (upd_push && (CntW'(i) == wr_pos)) begin
        upd_idx_d[i] = update_index;
        upd_tkn_d[i] = update_taken;
      end
    end
    upd_cnt_d = upd_cnt_q + CntW'(upd_push) - CntW'(upd_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      upd_cnt_q    <= '0;
      for (int i = 0; i < int'(UpdDepth); i++) begin
        upd_idx_q[i] <= '0;
        upd_tkn_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      upd_cnt_q    <= upd_cnt_d;
      upd_idx_q    <= upd_idx_d;
      upd_tkn_q    <= upd_tkn_d;
    end
  end

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Directed bench for gshare_pht_ctrl with a behavioural single-port PHT SRAM model.
module tb_gshare_pht_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       predict_valid, predict_ready;
  logic [7:0] predict_index;
  logic       predict_resp_valid;
  logic [1:0] predict_resp_ctr;
  logic       update_valid, update_ready, update_taken;
  logic [7:0] update_index;
  logic       init_done;
  logic       pht_csb, pht_web;
  logic [7:0] pht_addr;
  logic [1:0] pht_din;
  logic [1:0] pht_dout = 2'b00;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  gshare_pht_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .predict_valid     (predict_valid),
    .predict_ready     (predict_ready),
    .predict_index     (predict_index),
    .predict_resp_valid(predict_resp_valid),
    .predict_resp_ctr  (predict_resp_ctr),
    .update_valid      (update_valid),
    .update_ready      (update_ready),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .init_done         (init_done),
    .pht_csb           (pht_csb),
    .pht_web           (pht_web),
    .pht_addr          (pht_addr),
    .pht_din           (pht_din),
    .pht_dout          (pht_dout)
  );

  // SRAM: command captured at edge t; read data valid during t+1; write committed at edge t+1.
  logic [1:0] mem [256];
  logic       wr_pend = 1'b0;
  logic [7:0] wr_addr;
  logic [1:0] wr_din;
  initial for (int i = 0; i < 256; i++) mem[i] = 2'b11;
  always @(posedge clk) begin
    if (wr_pend) mem[wr_addr] = wr_din;
    wr_pend <= 1'b0;
    if (!pht_csb) begin
      if (!pht_web) begin
        wr_pend <= 1'b1;
        wr_addr <= pht_addr;
        wr_din  <= pht_din;
      end else begin
        pht_dout <= mem[pht_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
    check(tag, n, 256);
  endtask

  task automatic predict_chk(input logic [7:0] idx, input logic [1:0] exp_ctr, input string tag);
    predict_valid = 1'b1;
    predict_index = idx;
    #1;
    check({tag, "_ready"}, predict_ready, 1);
    check({tag, "_rd_cmd"}, {pht_csb, pht_web, pht_addr}, {2'b01, idx});
    tick();
    predict_valid = 1'b0;
    #1;
    check({tag, "_resp_valid"}, predict_resp_valid, 1);
    check({tag, "_resp_ctr"}, predict_resp_ctr, exp_ctr);
    check({tag, "_taken"}, predict_resp_ctr[1], exp_ctr[1]);
  endtask

  task automatic do_update(input logic [7:0] idx, input logic tkn, input logic [1:0] exp_din,
                           input string tag);
    check({tag, "_ready_in"}, update_ready, 1);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = tkn;
    tick();
    update_valid = 1'b0;
    #1;
`ifndef PHT_UPDATE_BUF_EN
    check({tag, "_ready_busy"}, update_ready, 0);
`endif
    check({tag, "_rd_cmd"}, {pht_csb, pht_web, pht_addr}, {2'b01, idx});
    tick();
    check({tag, "_wr_cmd"}, {pht_csb, pht_web, pht_addr, pht_din}, {2'b00, idx, exp_din});
    check({tag, "_wr_pred_rdy"}, predict_ready, 0);
    tick();
    check({tag, "_ready_back"}, update_ready, 1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    predict_valid = 1'b0;
    predict_index = '0;
    update_valid  = 1'b0;
    update_index  = '0;
    update_taken  = 1'b0;
    repeat (3) tick();

    check("rst_init_done", init_done, 0);
    check("rst_port", {pht_csb, pht_web, pht_addr, pht_din}, {2'b11, 8'h00, 2'b00});
    check("rst_resp", {predict_resp_valid, predict_resp_ctr}, 0);
    check("rst_readies", {predict_ready, update_ready}, 0);

    rst_n = 1'b1;
    #1;
    check("sweep0_cmd", {pht_csb, pht_web, pht_addr, pht_din}, {2'b00, 8'h00, 2'b01});
    check("init_readies", {predict_ready, update_ready}, 0);
    wait_init("init_cycles");
    check("accept_readies", {predict_ready, update_ready}, 2'b11);
    tick();
    cnt = 0;
    for (int i = 0; i < 256; i++) if (mem[i] == 2'b01) cnt++;
    check("init_fill", cnt, 256);

    predict_chk(8'h5A, 2'b01, "pred_5a");
    tick();
    check("idle_after_pred", {predict_resp_valid, pht_csb}, 2'b01);

    do_update(8'h10, 1'b1, 2'b10, "upd10_a");
    do_update(8'h10, 1'b1, 2'b11, "upd10_b");
    do_update(8'h10, 1'b1, 2'b11, "upd10_sat");
    predict_chk(8'h10, 2'b11, "pred_10");

    // Continuous predicts with one update queued: four grants, then the RMW takes the port.
    predict_valid = 1'b1;
    predict_index = 8'h40;
    update_valid  = 1'b1;
    update_index  = 8'h30;
    update_taken  = 1'b0;
    #1;
    check("starve_c0_rdy", predict_ready, 1);
    tick();
    update_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("starve_grant", {predict_ready, pht_csb, pht_addr}, {2'b10, 8'h40});
      check("starve_resp", {predict_resp_valid, predict_resp_ctr}, 3'b101);
      tick();
    end
    check("starve_upd_rd", {predict_ready, pht_csb, pht_web, pht_addr}, {3'b001, 8'h30});
    tick();
    check("starve_upd_wr", {predict_ready, pht_csb, pht_web, pht_addr, pht_din},
          {3'b000, 8'h30, 2'b00});
    tick();
    check("starve_resume", {predict_ready, pht_csb, pht_addr}, {2'b10, 8'h40});
    predict_valid = 1'b0;
    tick();
    tick();

    do_update(8'h20, 1'b0, 2'b00, "upd20");
    predict_chk(8'h20, 2'b00, "pred_20_fresh");
    tick();
    do_update(8'h20, 1'b0, 2'b00, "upd20_floor");

    // Reset in the middle of the sweep must restart it from address 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    repeat (100) tick();
    check("sweep_at_100", {pht_csb, pht_web, pht_addr}, {2'b00, 8'd100});
    rst_n = 1'b0;
    tick();
    check("midsweep_rst", {init_done, pht_csb, pht_addr}, {2'b01, 8'h00});
    rst_n = 1'b1;
    #1;
    check("resweep0", {pht_csb, pht_web, pht_addr}, {2'b00, 8'h00});
    wait_init("reinit_cycles");

`ifdef PHT_UPDATE_BUF_EN
    tick();
    update_valid = 1'b1;
    update_taken = 1'b1;
    update_index = 8'h60;
    #1;
    check("buf_c0_rdy", update_ready, 1);
    tick();
    #1;
    check("buf_c1_rdy", update_ready, 1);
    tick();
    update_index = 8'h61;
    update_taken = 1'b0;
    #1;
    check("buf_c2_full", update_ready, 0);
    tick();
    check("buf_c3_rdy", update_ready, 1);
    tick();
    update_valid = 1'b0;
    repeat (6) tick();
    check("buf_order_60", mem[8'h60], 2'b11);
    check("buf_order_61", mem[8'h61], 2'b00);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
